// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request
// outstanding at most, and feeds the 64-bit IF/ID register read by decode.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] ifid_reg,
  output logic        ifid_valid,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] req_pc, req_pc_next;
  logic        kill, kill_next;
  logic        hold_valid, hold_valid_next;
  logic [31:0] hold_pc, hold_pc_next;
  logic [31:0] hold_instr, hold_instr_next;
  logic [63:0] ifid_next;
  logic        ifid_valid_next;
  logic [31:0] target_pc;
  logic        resp_live;

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign imem_addr = pc;

  // A response is usable only if it was not killed and no redirect overrides it.
  assign resp_live = (state == WAIT) && imem_rvalid && !kill && !redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      hold_valid <= 1'b0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
      ifid_reg   <= {32'h0, NOP_INSTR};
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      imem_req   <= (state_next == REQ);
      req_pc     <= req_pc_next;
      kill       <= kill_next;
      hold_valid <= hold_valid_next;
      hold_pc    <= hold_pc_next;
      hold_instr <= hold_instr_next;
      ifid_reg   <= ifid_next;
      ifid_valid <= ifid_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    req_pc_next     = req_pc;
    kill_next       = kill;
    hold_valid_next = hold_valid;
    hold_pc_next    = hold_pc;
    hold_instr_next = hold_instr;
    ifid_next       = ifid_reg;
    ifid_valid_next = ifid_valid;

    case (state)
      IDLE: begin
        if (!hold_valid) state_next = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_next  = WAIT;
          req_pc_next = pc;
          pc_next     = pc + 32'd4;
          kill_next   = redirect;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_next  = 1'b0;
          state_next = (resp_live && stall) ? IDLE : REQ;
        end else if (redirect) begin
          kill_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (redirect) pc_next = target_pc;

    // IF/ID priority: redirect, stall, hold-buffer drain, fresh response, bubble.
    if (redirect) begin
      ifid_next       = {ifid_reg[63:32], NOP_INSTR};
      ifid_valid_next = 1'b0;
      hold_valid_next = 1'b0;
    end else if (stall) begin
      if (resp_live) begin
        hold_valid_next = 1'b1;
        hold_pc_next    = req_pc;
        hold_instr_next = imem_rdata;
      end
    end else if (hold_valid) begin
      ifid_next       = {hold_pc, hold_instr};
      ifid_valid_next = 1'b1;
      hold_valid_next = 1'b0;
    end else if (resp_live) begin
      ifid_next       = {req_pc, imem_rdata};
      ifid_valid_next = 1'b1;
    end else begin
      ifid_next       = {ifid_reg[63:32], NOP_INSTR};
      ifid_valid_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a behavioural instruction memory feeds a scoreboard of the
// IF/ID words that must appear, plus directed stall/redirect/wrap scenarios.
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] ifid_reg;
  logic        ifid_valid;
  logic [31:0] pc;

  ifetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifid_reg    (ifid_reg),
    .ifid_valid  (ifid_valid),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic [63:0] expq[$];

  logic        drv_stall = 1'b0;
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_rpc = 32'h0;
  logic        gnt_en = 1'b1;
  int          lat = 1;

  logic        outstanding = 1'b0;
  logic        stale = 1'b0;
  logic [31:0] out_addr = 32'h0;
  int          cnt = 0;

  logic        last_stall = 1'b0;
  logic        last_redirect = 1'b0;
  logic [63:0] prev_ifid = 64'h0;
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00A0_0093 + {a[24:0], 7'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, let a posedge pass, then check.
  task automatic applyStimulus();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (outstanding) begin
      if (cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
        outstanding = 1'b0;
        if (!stale && !drv_redirect) expq.push_back({out_addr, mem_word(out_addr)});
        stale = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (drv_redirect && outstanding) stale = 1'b1;
    if (imem_req && gnt_en && !outstanding) begin
      imem_gnt    = 1'b1;
      outstanding = 1'b1;
      out_addr    = imem_addr;
      cnt         = lat;
      stale       = drv_redirect;
    end
    stall         = drv_stall;
    redirect      = drv_redirect;
    redirect_pc   = drv_rpc;
    last_stall    = drv_stall;
    last_redirect = drv_redirect;
    prev_ifid     = ifid_reg;
    prev_valid    = ifid_valid;
    drv_redirect  = 1'b0;

    @(negedge clk);

    if (last_redirect) begin
      checkOutput("redir_valid", {63'b0, ifid_valid}, 64'd0);
      checkOutput("redir_nop", {32'b0, ifid_reg[31:0]}, {32'b0, NOP});
    end else if (last_stall) begin
      checkOutput("stall_hold_reg", ifid_reg, prev_ifid);
      checkOutput("stall_hold_valid", {63'b0, ifid_valid}, {63'b0, prev_valid});
    end else if (ifid_valid) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_instr", {63'b0, ifid_valid}, 64'd0);
      end else begin
        pops++;
        checkOutput("ifid", ifid_reg, expq.pop_front());
      end
    end else begin
      checkOutput("bubble_nop", {32'b0, ifid_reg[31:0]}, {32'b0, NOP});
    end
  endtask

  task automatic waitReq();
    int n;
    n = 0;
    gnt_en    = 1'b0;
    drv_stall = 1'b0;
    while (!imem_req && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("wait_req", {63'b0, imem_req}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] req_addr;
    int          pops_before;
    int          n;

    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    repeat (3) @(negedge clk);
    checkOutput("rst_ifid", ifid_reg, 64'h0000_0000_0000_0013);
    checkOutput("rst_valid", {63'b0, ifid_valid}, 64'd0);
    checkOutput("rst_req", {63'b0, imem_req}, 64'd0);
    checkOutput("rst_addr", {32'b0, imem_addr}, 64'd0);

    $display("[TB] reset released, straight-line fetch");
    reset  = 1'b1;
    gnt_en = 1'b1;
    lat    = 1;
    applyStimulus();
    checkOutput("first_req", {63'b0, imem_req}, 64'd1);
    checkOutput("first_addr", {32'b0, imem_addr}, 64'd0);
    pops = 0;
    repeat (8) applyStimulus();
    checkOutput("straight_count", pops, 64'd4);

    $display("[TB] random grant/latency/stall traffic");
    for (int i = 0; i < 60; i++) begin
      gnt_en    = ($urandom_range(0, 3) != 0);
      lat       = $urandom_range(1, 3);
      drv_stall = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("[TB] stall across a response");
    waitReq();
    lat      = 2;
    gnt_en   = 1'b1;
    req_addr = imem_addr;
    applyStimulus();
    gnt_en    = 1'b0;
    drv_stall = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("stall_req_off", {63'b0, imem_req}, 64'd0);
    applyStimulus();
    checkOutput("stall_req_still_off", {63'b0, imem_req}, 64'd0);
    drv_stall   = 1'b0;
    pops_before = pops;
    applyStimulus();
    checkOutput("drain_pop", pops - pops_before, 64'd1);
    checkOutput("drain_ifid", ifid_reg, {req_addr, mem_word(req_addr)});
    applyStimulus();
    checkOutput("resume_req", {63'b0, imem_req}, 64'd1);
    checkOutput("resume_addr", {32'b0, imem_addr}, {32'b0, req_addr + 32'd4});

    $display("[TB] redirect with stale response");
    drv_redirect = 1'b1;
    drv_rpc      = 32'h8;
    applyStimulus();
    checkOutput("retarget_addr", {32'b0, imem_addr}, 64'h8);
    checkOutput("retarget_req", {63'b0, imem_req}, 64'd1);
    lat    = 3;
    gnt_en = 1'b1;
    applyStimulus();
    gnt_en = 1'b0;
    checkOutput("after_gnt_addr", {32'b0, imem_addr}, 64'hC);
    drv_redirect = 1'b1;
    drv_rpc      = 32'h100;
    applyStimulus();
    checkOutput("kill_addr", {32'b0, imem_addr}, 64'h100);
    checkOutput("kill_req", {63'b0, imem_req}, 64'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("kill_valid", {63'b0, ifid_valid}, 64'd0);
    checkOutput("stale_next_req", {63'b0, imem_req}, 64'd1);
    checkOutput("stale_next_addr", {32'b0, imem_addr}, 64'h100);
    gnt_en = 1'b1;
    lat    = 1;
    applyStimulus();
    gnt_en = 1'b0;
    applyStimulus();
    checkOutput("target_ifid", ifid_reg, {32'h100, mem_word(32'h100)});

    $display("[TB] redirect + stall + rvalid together");
    waitReq();
    lat    = 1;
    gnt_en = 1'b1;
    applyStimulus();
    gnt_en       = 1'b0;
    drv_stall    = 1'b1;
    drv_redirect = 1'b1;
    drv_rpc      = 32'h200;
    applyStimulus();
    checkOutput("sim_valid", {63'b0, ifid_valid}, 64'd0);
    checkOutput("sim_req", {63'b0, imem_req}, 64'd1);
    checkOutput("sim_addr", {32'b0, imem_addr}, 64'h200);
    drv_stall = 1'b0;
    applyStimulus();
    checkOutput("sim_no_late", {63'b0, ifid_valid}, 64'd0);

    $display("[TB] alignment and PC wrap");
    waitReq();
    drv_redirect = 1'b1;
    drv_rpc      = 32'h103;
    applyStimulus();
    checkOutput("align_addr", {32'b0, imem_addr}, 64'h100);
    drv_redirect = 1'b1;
    drv_rpc      = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("wrap_target", {32'b0, imem_addr}, 64'hFFFF_FFFC);
    gnt_en = 1'b1;
    lat    = 1;
    applyStimulus();
    gnt_en = 1'b0;
    checkOutput("wrap_addr", {32'b0, imem_addr}, 64'd0);
    applyStimulus();
    checkOutput("wrap_ifid", ifid_reg, {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});

    n = 0;
    while ((outstanding || expq.size() != 0) && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("queue_empty", expq.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
